// File: rtl/mips_multicycle_ctrl_if.sv
// Memory handshake bundle between the multicycle controller and its
// wait-state instruction/data memories.
interface mips_multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;
  logic memwrite;

  modport master (
    output imem_req, dmem_req, memwrite,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, memwrite,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: BOOT/FETCH/DECODE/EXEC/MEM/WB with memory
// wait-state handshakes, timeout and illegal-instruction traps.
module mips_multicycle_ctrl #(
  parameter int TIMEOUT         = 16,
  parameter int CNT_W           = 8,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic                   zero,
  mips_multicycle_ctrl_if.master mem,
  output logic                   ir_en,
  output logic                   mdr_en,
  output logic                   pc_en,
  output logic [1:0]             pcsrc,
  output logic                   regwrite,
  output logic                   regdst,
  output logic                   memtoreg,
  output logic                   alusrcbimm,
  output logic [3:0]             alucontrol,
  output logic                   halted,
  output logic [1:0]             trap_cause,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_R:    is_legal = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) ||
                          (fn == 6'h25) || (fn == 6'h2A);
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] rtype_alu(input logic [5:0] fn);
    case (fn)
      6'h22:   rtype_alu = ALU_SUB;
      6'h24:   rtype_alu = ALU_AND;
      6'h25:   rtype_alu = ALU_OR;
      6'h2A:   rtype_alu = ALU_SLT;
      default: rtype_alu = ALU_ADD;
    endcase
  endfunction

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       cause_q, cause_nxt;
  logic             timeout_hit;
  logic             waiting;

  // A ready in the last allowed cycle is checked first, so it beats the timeout.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  assign waiting     = (state_nxt == state_q) && ((state_q == FETCH) || (state_q == MEM));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_nxt;
      cause_q <= cause_nxt;
      if (state_nxt != state_q) cnt_q <= '0;
      else if (waiting)         cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    cause_nxt    = cause_q;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.memwrite = 1'b0;
    ir_en        = 1'b0;
    mdr_en       = 1'b0;
    pc_en        = 1'b0;
    pcsrc        = 2'd0;
    regwrite     = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrcbimm   = 1'b0;
    alucontrol   = 4'b0000;
    halted       = 1'b0;
    case (state_q)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ready) begin
          ir_en     = 1'b1;
          pc_en     = 1'b1;
          state_nxt = DECODE;
        end else if (timeout_hit) begin
          state_nxt = TRAP;
          cause_nxt = 2'd2;
        end
      end
      DECODE: begin
        if (!is_legal(opcode, funct)) begin
          if (TRAP_ON_ILLEGAL != 0) begin
            state_nxt = TRAP;
            cause_nxt = 2'd1;
          end else begin
            state_nxt = FETCH;
          end
        end else if (opcode == OP_J) begin
          pc_en     = 1'b1;
          pcsrc     = 2'd2;
          state_nxt = FETCH;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (opcode == OP_R)        alucontrol = rtype_alu(funct);
        else if (opcode == OP_BEQ) alucontrol = ALU_SUB;
        else                       alucontrol = ALU_ADD;
        alusrcbimm = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_ADDI);
        case (opcode)
          OP_BEQ: begin
            pc_en     = zero;
            pcsrc     = 2'd1;
            state_nxt = FETCH;
          end
          OP_LW, OP_SW:  state_nxt = MEM;
          OP_R, OP_ADDI: state_nxt = WB;
          default:       state_nxt = FETCH;
        endcase
      end
      MEM: begin
        mem.dmem_req = 1'b1;
        mem.memwrite = (opcode == OP_SW);
        alucontrol   = ALU_ADD;
        alusrcbimm   = 1'b1;
        if (mem.dmem_ready) begin
          if (opcode == OP_LW) begin
            mdr_en    = 1'b1;
            state_nxt = WB;
          end else begin
            state_nxt = FETCH;
          end
        end else if (timeout_hit) begin
          state_nxt = TRAP;
          cause_nxt = 2'd3;
        end
      end
      WB: begin
        regwrite  = 1'b1;
        regdst    = (opcode == OP_R);
        memtoreg  = (opcode == OP_LW);
        state_nxt = FETCH;
      end
      TRAP: halted = 1'b1;
      // The unused code 7 behaves exactly like BOOT.
      default: state_nxt = FETCH;
    endcase
  end

  assign trap_cause = cause_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: unit A traps on illegal/timeout
// (TIMEOUT=4), unit B retires illegal ops as NOP and waits forever.
module tb_mips_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       imem_rdy = 1'b0;
  logic       dmem_rdy = 1'b0;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl_if ia ();
  mips_multicycle_ctrl_if ib ();
  assign ia.imem_ready = imem_rdy;
  assign ia.dmem_ready = dmem_rdy;
  assign ib.imem_ready = imem_rdy;
  assign ib.dmem_ready = dmem_rdy;

  logic       a_ir_en, a_mdr_en, a_pc_en, a_regwrite, a_regdst, a_memtoreg, a_alusrcbimm, a_halted;
  logic [1:0] a_pcsrc, a_trap_cause;
  logic [3:0] a_alucontrol;
  logic [2:0] a_state;
  logic       b_ir_en, b_mdr_en, b_pc_en, b_regwrite, b_regdst, b_memtoreg, b_alusrcbimm, b_halted;
  logic [1:0] b_pcsrc, b_trap_cause;
  logic [3:0] b_alucontrol;
  logic [2:0] b_state;

  mips_multicycle_ctrl #(.TIMEOUT(4), .CNT_W(8), .TRAP_ON_ILLEGAL(1)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem(ia),
    .ir_en(a_ir_en), .mdr_en(a_mdr_en), .pc_en(a_pc_en), .pcsrc(a_pcsrc),
    .regwrite(a_regwrite), .regdst(a_regdst), .memtoreg(a_memtoreg),
    .alusrcbimm(a_alusrcbimm), .alucontrol(a_alucontrol), .halted(a_halted),
    .trap_cause(a_trap_cause), .state_o(a_state)
  );

  mips_multicycle_ctrl #(.TIMEOUT(0), .CNT_W(8), .TRAP_ON_ILLEGAL(0)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem(ib),
    .ir_en(b_ir_en), .mdr_en(b_mdr_en), .pc_en(b_pc_en), .pcsrc(b_pcsrc),
    .regwrite(b_regwrite), .regdst(b_regdst), .memtoreg(b_memtoreg),
    .alusrcbimm(b_alusrcbimm), .alucontrol(b_alucontrol), .halted(b_halted),
    .trap_cause(b_trap_cause), .state_o(b_state)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across one edge, then release it one step after the next edge.
  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // 1: reset for 3 cycles, then add
    repeat (3) tick();
    chk("rst_state", a_state, 0);
    chk("rst_imem_req", ia.imem_req, 0);
    chk("rst_halted", a_halted, 0);
    chk("rst_cause", a_trap_cause, 0);
    chk("rst_pc_en", a_pc_en, 0);
    opcode = 6'h00; funct = 6'h20; imem_rdy = 1'b1;
    reset = 1'b1;
    chk("add_boot", a_state, 0);
    chk("add_boot_req", ia.imem_req, 0);
    tick();
    chk("add_fetch", a_state, 1);
    chk("add_fetch_req", ia.imem_req, 1);
    chk("add_ir_en", a_ir_en, 1);
    chk("add_fetch_pc_en", a_pc_en, 1);
    chk("add_fetch_pcsrc", a_pcsrc, 0);
    chk("add_fetch_rw", a_regwrite, 0);
    tick();
    chk("add_decode", a_state, 2);
    chk("add_decode_rw", a_regwrite, 0);
    tick();
    chk("add_exec", a_state, 3);
    chk("add_alu", a_alucontrol, 4'b0010);
    chk("add_bimm", a_alusrcbimm, 0);
    chk("add_exec_rw", a_regwrite, 0);
    tick();
    chk("add_wb", a_state, 5);
    chk("add_wb_rw", a_regwrite, 1);
    chk("add_regdst", a_regdst, 1);
    chk("add_memtoreg", a_memtoreg, 0);
    tick();
    chk("add_refetch", a_state, 1);
    chk("add_refetch_rw", a_regwrite, 0);

    // 2: lw with dmem_ready low for 3 MEM cycles, ready in the 4th
    opcode = 6'h23; funct = 6'h00;
    tick();
    chk("lw_decode", a_state, 2);
    tick();
    chk("lw_exec_alu", a_alucontrol, 4'b0010);
    chk("lw_exec_bimm", a_alusrcbimm, 1);
    tick();
    chk("lw_mem1", a_state, 4);
    chk("lw_mem1_req", ia.dmem_req, 1);
    chk("lw_mem1_wr", ia.memwrite, 0);
    chk("lw_mem1_mdr", a_mdr_en, 0);
    tick();
    chk("lw_mem2", a_state, 4);
    chk("lw_mem2_req", ia.dmem_req, 1);
    tick();
    chk("lw_mem3", a_state, 4);
    tick();
    dmem_rdy = 1'b1;
    #1;
    chk("lw_mem4", a_state, 4);
    chk("lw_mem4_req", ia.dmem_req, 1);
    chk("lw_mem4_mdr", a_mdr_en, 1);
    chk("lw_mem4_wr", ia.memwrite, 0);
    tick();
    dmem_rdy = 1'b0;
    chk("lw_wb", a_state, 5);
    chk("lw_wb_rw", a_regwrite, 1);
    chk("lw_memtoreg", a_memtoreg, 1);
    chk("lw_regdst", a_regdst, 0);
    chk("lw_wb_cause", a_trap_cause, 0);
    tick();
    chk("lw_refetch", a_state, 1);

    // 3: beq taken, then not taken, then j
    opcode = 6'h04; zero = 1'b1;
    tick();
    chk("beq1_decode", a_state, 2);
    tick();
    chk("beq1_exec", a_state, 3);
    chk("beq1_pc_en", a_pc_en, 1);
    chk("beq1_pcsrc", a_pcsrc, 1);
    chk("beq1_alu", a_alucontrol, 4'b0110);
    tick();
    chk("beq1_fetch", a_state, 1);
    zero = 1'b0;
    tick();
    tick();
    chk("beq0_exec", a_state, 3);
    chk("beq0_pc_en", a_pc_en, 0);
    chk("beq0_alu", a_alucontrol, 4'b0110);
    tick();
    chk("beq0_fetch", a_state, 1);
    opcode = 6'h02;
    tick();
    chk("j_decode", a_state, 2);
    chk("j_pc_en", a_pc_en, 1);
    chk("j_pcsrc", a_pcsrc, 2);
    tick();
    chk("j_fetch", a_state, 1);

    // 4: imem stuck low -> imem timeout trap on A; B keeps waiting
    imem_rdy = 1'b0; opcode = 6'h00; funct = 6'h20;
    do_reset();
    tick();
    chk("to_fetch", a_state, 1);
    tick(); tick(); tick();
    chk("to_fetch4", a_state, 1);
    chk("to_fetch4_req", ia.imem_req, 1);
    tick();
    chk("to_trap", a_state, 6);
    chk("to_cause", a_trap_cause, 2);
    chk("to_halted", a_halted, 1);
    chk("to_no_req", ia.imem_req, 0);
    chk("to_b_waits", b_state, 1);
    imem_rdy = 1'b1;
    tick();
    chk("to_sticky", a_state, 6);
    chk("to_sticky_req", ia.imem_req, 0);
    chk("to_sticky_pc_en", a_pc_en, 0);
    chk("to_sticky_cause", a_trap_cause, 2);
    imem_rdy = 1'b0;
    do_reset();
    chk("to_rst_cause", a_trap_cause, 0);
    tick(); tick(); tick(); tick();
    imem_rdy = 1'b1;
    #1;
    chk("to_late_ir_en", a_ir_en, 1);
    tick();
    chk("to_late_decode", a_state, 2);
    chk("to_late_cause", a_trap_cause, 0);

    // 4b: dmem stuck low on lw -> dmem timeout trap
    opcode = 6'h23; dmem_rdy = 1'b0;
    do_reset();
    repeat (4) tick();
    chk("dto_mem", a_state, 4);
    repeat (3) tick();
    chk("dto_mem4", a_state, 4);
    tick();
    chk("dto_trap", a_state, 6);
    chk("dto_cause", a_trap_cause, 3);
    chk("dto_no_dreq", ia.dmem_req, 0);

    // 5: illegal opcode 0x3F, and an illegal R-type funct
    opcode = 6'h3F; funct = 6'h00;
    do_reset();
    tick(); tick();
    chk("ill_decode", a_state, 2);
    tick();
    chk("ill_trap", a_state, 6);
    chk("ill_cause", a_trap_cause, 1);
    chk("ill_halted", a_halted, 1);
    chk("ill_b_fetch", b_state, 1);
    chk("ill_b_rw", b_regwrite, 0);
    chk("ill_b_wr", ib.memwrite, 0);
    chk("ill_b_halted", b_halted, 0);
    opcode = 6'h00; funct = 6'h21;
    do_reset();
    tick(); tick(); tick();
    chk("illf_trap", a_state, 6);
    chk("illf_cause", a_trap_cause, 1);

    // 6: sw, reset asserted while MEM waits
    opcode = 6'h2B; funct = 6'h00; dmem_rdy = 1'b0;
    do_reset();
    tick(); tick(); tick();
    chk("sw_exec_bimm", a_alusrcbimm, 1);
    tick();
    chk("sw_mem", a_state, 4);
    chk("sw_mem_wr", ia.memwrite, 1);
    chk("sw_mem_req", ia.dmem_req, 1);
    tick();
    reset = 1'b0;
    #1;
    chk("sw_rst_wr", ia.memwrite, 0);
    chk("sw_rst_req", ia.dmem_req, 0);
    chk("sw_rst_state", a_state, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("sw_resume", a_state, 1);
    chk("sw_resume_req", ia.imem_req, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
